// File: rtl/score_arbiter_if.sv
// score_arbiter_if: signal bundle between the two score-check requesters,
// the shared score tracker and score_arbiter. The master side drives the
// requests and tracker responses, and the slave side is the arbiter.
interface score_arbiter_if;
   logic [1:0] req_in;
   logic [6:0] score0_in;
   logic [6:0] score1_in;
   logic [2:0] id0_in;
   logic [2:0] id1_in;
   logic [1:0] guest_in;
   logic       score_req;
   logic [6:0] score_out;
   logic [2:0] intPlayID_out;
   logic       isGuest_out;
   logic       valid_in;
   logic       personalwin_in;
   logic       globalwin_in;
   logic [1:0] valid_out;
   logic [1:0] personalwin_out;
   logic [1:0] globalwin_out;
   logic       busy;
   logic       timeout_out;

   modport master (
      output req_in, score0_in, score1_in, id0_in, id1_in, guest_in,
      output valid_in, personalwin_in, globalwin_in,
      input  score_req, score_out, intPlayID_out, isGuest_out,
      input  valid_out, personalwin_out, globalwin_out, busy, timeout_out
   );

   modport slave (
      input  req_in, score0_in, score1_in, id0_in, id1_in, guest_in,
      input  valid_in, personalwin_in, globalwin_in,
      output score_req, score_out, intPlayID_out, isGuest_out,
      output valid_out, personalwin_out, globalwin_out, busy, timeout_out
   );
endinterface

// File: rtl/score_arbiter.sv
// score_arbiter: shares one score tracker between two requesters.
// Requests are latched per requester and served round-robin on ties.
// The tracker response is routed back to the granted requester.
// All outputs are registered, so they trail the FSM state by one edge.
// Build option SCORE_ARB_TIMEOUT_EN abandons a transaction after
// TIMEOUT_CYC cycles in WAIT without a tracker response.
module score_arbiter
`ifdef SCORE_ARB_TIMEOUT_EN
#(
   parameter logic [7:0] TIMEOUT_CYC = 8'd200
)
`endif
(
   input logic            clk,
   input logic            rst,
   score_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      RETURN = 2'd3
   } state_t;

   state_t     state, state_nx;
   logic [1:0] pending, pending_nx;
   logic [6:0] cap_score0, cap_score0_nx, cap_score1, cap_score1_nx;
   logic [2:0] cap_id0, cap_id0_nx, cap_id1, cap_id1_nx;
   logic [1:0] cap_guest, cap_guest_nx;
   logic       last_served, last_served_nx;
   logic       grant, grant_nx, g_sel;
   logic [1:0] grant_mask;
   logic       win_p, win_p_nx, win_g, win_g_nx;
   logic       score_req, score_req_nx;
   logic [6:0] score_out, score_out_nx;
   logic [2:0] id_out, id_out_nx;
   logic       guest_out, guest_out_nx;
   logic [1:0] valid_out, valid_out_nx;
   logic [1:0] pwin_out, pwin_out_nx;
   logic [1:0] gwin_out, gwin_out_nx;
   logic       busy, busy_nx;
`ifdef SCORE_ARB_TIMEOUT_EN
   logic [7:0] tcnt, tcnt_nx;
   logic       timed_out, timed_out_nx;
   logic       timeout_out, timeout_out_nx;
`endif

   // One-hot select of the requester currently granted.
   always_comb begin
      if (grant) grant_mask = 2'b10;
      else       grant_mask = 2'b01;
   end

   // Next-state, request capture and registered-output computation.
   always_comb begin
      state_nx       = state;
      pending_nx     = pending;
      cap_score0_nx  = cap_score0;
      cap_score1_nx  = cap_score1;
      cap_id0_nx     = cap_id0;
      cap_id1_nx     = cap_id1;
      cap_guest_nx   = cap_guest;
      last_served_nx = last_served;
      grant_nx       = grant;
      g_sel          = 1'b0;
      win_p_nx       = win_p;
      win_g_nx       = win_g;
      score_out_nx   = score_out;
      id_out_nx      = id_out;
      guest_out_nx   = guest_out;
      score_req_nx   = 1'b0;
      valid_out_nx   = 2'b00;
      pwin_out_nx    = 2'b00;
      gwin_out_nx    = 2'b00;
      busy_nx        = (state != IDLE);
`ifdef SCORE_ARB_TIMEOUT_EN
      tcnt_nx        = tcnt;
      timed_out_nx   = timed_out;
      timeout_out_nx = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (pending != 2'b00) begin
               // On a tie, serve whoever was not served last.
               if (pending == 2'b11) g_sel = ~last_served;
               else                  g_sel = pending[1];
               grant_nx       = g_sel;
               last_served_nx = g_sel;
               score_out_nx   = g_sel ? cap_score1   : cap_score0;
               id_out_nx      = g_sel ? cap_id1      : cap_id0;
               guest_out_nx   = g_sel ? cap_guest[1] : cap_guest[0];
               state_nx       = ISSUE;
            end else begin
               state_nx = IDLE;
            end
         end
         ISSUE: begin
            score_req_nx = 1'b1;
            state_nx     = WAIT;
`ifdef SCORE_ARB_TIMEOUT_EN
            tcnt_nx      = 8'd0;
`endif
         end
         WAIT: begin
            if (bus.valid_in) begin
               win_p_nx = bus.personalwin_in;
               win_g_nx = bus.globalwin_in;
               state_nx = RETURN;
`ifdef SCORE_ARB_TIMEOUT_EN
               timed_out_nx = 1'b0;
`endif
            end else begin
`ifdef SCORE_ARB_TIMEOUT_EN
               if (tcnt == TIMEOUT_CYC - 8'd1) begin
                  win_p_nx     = 1'b0;
                  win_g_nx     = 1'b0;
                  timed_out_nx = 1'b1;
                  state_nx     = RETURN;
               end else begin
                  tcnt_nx  = tcnt + 8'd1;
                  state_nx = WAIT;
               end
`else
               state_nx = WAIT;
`endif
            end
         end
         RETURN: begin
            valid_out_nx = grant_mask;
            pwin_out_nx  = grant_mask & {2{win_p}};
            gwin_out_nx  = grant_mask & {2{win_g}};
            pending_nx   = pending & ~grant_mask;
            state_nx     = IDLE;
`ifdef SCORE_ARB_TIMEOUT_EN
            timeout_out_nx = timed_out;
`endif
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
      // Requests latch only when not already pending; checking after the
      // RETURN clear lets a request in that same cycle start a new one.
      if (bus.req_in[0] && !pending_nx[0]) begin
         pending_nx[0]   = 1'b1;
         cap_score0_nx   = bus.score0_in;
         cap_id0_nx      = bus.id0_in;
         cap_guest_nx[0] = bus.guest_in[0];
      end else begin
         cap_score0_nx = cap_score0;
      end
      if (bus.req_in[1] && !pending_nx[1]) begin
         pending_nx[1]   = 1'b1;
         cap_score1_nx   = bus.score1_in;
         cap_id1_nx      = bus.id1_in;
         cap_guest_nx[1] = bus.guest_in[1];
      end else begin
         cap_score1_nx = cap_score1;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         pending     <= 2'b00;
         cap_score0  <= 7'd0;
         cap_score1  <= 7'd0;
         cap_id0     <= 3'd0;
         cap_id1     <= 3'd0;
         cap_guest   <= 2'b00;
         last_served <= 1'b1;
         grant       <= 1'b0;
         win_p       <= 1'b0;
         win_g       <= 1'b0;
         score_req   <= 1'b0;
         score_out   <= 7'd0;
         id_out      <= 3'd0;
         guest_out   <= 1'b0;
         valid_out   <= 2'b00;
         pwin_out    <= 2'b00;
         gwin_out    <= 2'b00;
         busy        <= 1'b0;
`ifdef SCORE_ARB_TIMEOUT_EN
         tcnt        <= 8'd0;
         timed_out   <= 1'b0;
         timeout_out <= 1'b0;
`endif
      end else begin
         state       <= state_nx;
         pending     <= pending_nx;
         cap_score0  <= cap_score0_nx;
         cap_score1  <= cap_score1_nx;
         cap_id0     <= cap_id0_nx;
         cap_id1     <= cap_id1_nx;
         cap_guest   <= cap_guest_nx;
         last_served <= last_served_nx;
         grant       <= grant_nx;
         win_p       <= win_p_nx;
         win_g       <= win_g_nx;
         score_req   <= score_req_nx;
         score_out   <= score_out_nx;
         id_out      <= id_out_nx;
         guest_out   <= guest_out_nx;
         valid_out   <= valid_out_nx;
         pwin_out    <= pwin_out_nx;
         gwin_out    <= gwin_out_nx;
         busy        <= busy_nx;
`ifdef SCORE_ARB_TIMEOUT_EN
         tcnt        <= tcnt_nx;
         timed_out   <= timed_out_nx;
         timeout_out <= timeout_out_nx;
`endif
      end
   end

   assign bus.score_req       = score_req;
   assign bus.score_out       = score_out;
   assign bus.intPlayID_out   = id_out;
   assign bus.isGuest_out     = guest_out;
   assign bus.valid_out       = valid_out;
   assign bus.personalwin_out = pwin_out;
   assign bus.globalwin_out   = gwin_out;
   assign bus.busy            = busy;
`ifdef SCORE_ARB_TIMEOUT_EN
   assign bus.timeout_out     = timeout_out;
`else
   assign bus.timeout_out     = 1'b0;
`endif

endmodule

// File: tb/tb_score_arbiter.sv
// tb_score_arbiter: cycle vector table, hand-written arbitration
// sequences and a randomized run against a transaction-level model.
module tb_score_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   score_arbiter_if bus_if ();

   always #5 clk = ~clk;

`ifdef SCORE_ARB_TIMEOUT_EN
   score_arbiter #(.TIMEOUT_CYC(8'd4)) dut (.clk(clk), .rst(rst), .bus(bus_if));
`else
   score_arbiter dut (.clk(clk), .rst(rst), .bus(bus_if));
`endif

   typedef struct {
      logic       rst;
      logic [1:0] req;
      logic [6:0] s0;
      logic [2:0] i0;
      logic [6:0] s1;
      logic [2:0] i1;
      logic [1:0] guest;
      logic       v;
      logic       pw;
      logic       gw;
      logic       e_sreq;
      logic [1:0] e_vo;
      logic [1:0] e_pw;
      logic [1:0] e_gw;
      logic       e_busy;
      logic [6:0] e_score;
      logic [2:0] e_id;
      logic       e_guest;
   } vec_t;

   vec_t tbl [19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [19:0] out_word();
      return {bus_if.score_req, bus_if.valid_out, bus_if.personalwin_out,
              bus_if.globalwin_out, bus_if.busy, bus_if.score_out,
              bus_if.intPlayID_out, bus_if.isGuest_out, bus_if.timeout_out};
   endfunction

   function automatic logic [1:0] onehot(input logic g);
      return g ? 2'b10 : 2'b01;
   endfunction

   task automatic drive(input logic r, input logic [1:0] req, input logic [6:0] s0,
                        input logic [2:0] i0, input logic [6:0] s1, input logic [2:0] i1,
                        input logic [1:0] gu, input logic v, input logic pw, input logic gw);
      rst                   = r;
      bus_if.req_in         = req;
      bus_if.score0_in      = s0;
      bus_if.id0_in         = i0;
      bus_if.score1_in      = s1;
      bus_if.id1_in         = i1;
      bus_if.guest_in       = gu;
      bus_if.valid_in       = v;
      bus_if.personalwin_in = pw;
      bus_if.globalwin_in   = gw;
   endtask

   // Waits for the grant of requester g, checks its data, answers it and
   // checks the routed response pulse.
   task automatic serve(input logic g, input logic [6:0] sc, input logic [2:0] id,
                        input logic gu, input logic pw, input logic gw);
      int n;
      n = 0;
      while (bus_if.score_req !== 1'b1 && n < 12) begin
         @(negedge clk);
         n++;
      end
      check("serve_wait", 32'(n < 12), 32'd1);
      if (n < 12) begin
         check("serve_grant", {bus_if.busy, bus_if.score_out, bus_if.intPlayID_out, bus_if.isGuest_out},
               {1'b1, sc, id, gu});
         drive(1'b1, 2'b00, 7'd0, 3'd0, 7'd0, 3'd0, 2'b00, 1'b1, pw, gw);
         @(negedge clk);
         drive(1'b1, 2'b00, 7'd0, 3'd0, 7'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
         check("serve_no_early", bus_if.valid_out, 2'b00);
         @(negedge clk);
         check("serve_resp", {bus_if.valid_out, bus_if.personalwin_out, bus_if.globalwin_out},
               {onehot(g), onehot(g) & {2{pw}}, onehot(g) & {2{gw}}});
         @(negedge clk);
         check("serve_pulse_end", bus_if.valid_out, 2'b00);
      end
   endtask

   // Randomized-run model state.
   logic [1:0] mpend, mprev, pgrant, exp_vo;
   logic [6:0] mscore [2];
   logic [2:0] mid [2];
   logic       mguest [2];
   logic       mlast, awaiting, gcur, rel, g, rpw, rgw;
   int         resp_delay, vo_due, stall, cnt;

   initial begin
      drive(1'b0, 2'b00, 7'd0, 3'd0, 7'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
      //        rst  req    s0     i0    s1    i1    gu     v     pw    gw  | sreq  vo     pw     gw     busy  score  id    guest
      tbl[0]  = '{1'b0, 2'b00, 7'd0,  3'd0, 7'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 7'd0,  3'd0, 1'b0};
      tbl[1]  = '{1'b1, 2'b01, 7'd42, 3'd5, 7'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 7'd0,  3'd0, 1'b0};
      tbl[2]  = '{1'b1, 2'b00, 7'd42, 3'd5, 7'd0, 3'd0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 7'd42, 3'd5, 1'b0};
      tbl[3]  = '{1'b1, 2'b00, 7'd42, 3'd5, 7'd0, 3'd0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 7'd42, 3'd5, 1'b0};
      tbl[4]  = '{1'b1, 2'b00, 7'd42, 3'd5, 7'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 7'd42, 3'd5, 1'b0};
      tbl[5]  = '{1'b1, 2'b00, 7'd42, 3'd5, 7'd0, 3'd0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 7'd42, 3'd5, 1'b0};
      tbl[6]  = '{1'b1, 2'b00, 7'd42, 3'd5, 7'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 7'd42, 3'd5, 1'b0};
      tbl[7]  = '{1'b1, 2'b00, 7'd42, 3'd5, 7'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 7'd42, 3'd5, 1'b0};
      tbl[8]  = '{1'b1, 2'b10, 7'd0,  3'd0, 7'd9, 3'd3, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 7'd42, 3'd5, 1'b0};
      tbl[9]  = '{1'b1, 2'b00, 7'd0,  3'd0, 7'd9, 3'd3, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 7'd9,  3'd3, 1'b1};
      tbl[10] = '{1'b1, 2'b00, 7'd0,  3'd0, 7'd9, 3'd3, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 7'd9,  3'd3, 1'b1};
      tbl[11] = '{1'b0, 2'b11, 7'd0,  3'd0, 7'd9, 3'd3, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 7'd0,  3'd0, 1'b0};
      tbl[12] = '{1'b1, 2'b00, 7'd0,  3'd0, 7'd0, 3'd0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 7'd0,  3'd0, 1'b0};
      tbl[13] = '{1'b1, 2'b01, 7'd17, 3'd2, 7'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 7'd0,  3'd0, 1'b0};
      tbl[14] = '{1'b1, 2'b00, 7'd17, 3'd2, 7'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 7'd17, 3'd2, 1'b0};
      tbl[15] = '{1'b1, 2'b00, 7'd17, 3'd2, 7'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 7'd17, 3'd2, 1'b0};
      tbl[16] = '{1'b1, 2'b00, 7'd17, 3'd2, 7'd0, 3'd0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 7'd17, 3'd2, 1'b0};
      tbl[17] = '{1'b1, 2'b00, 7'd17, 3'd2, 7'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 1'b1, 7'd17, 3'd2, 1'b0};
      tbl[18] = '{1'b1, 2'b00, 7'd17, 3'd2, 7'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 7'd17, 3'd2, 1'b0};

      // Vector i is applied before edge i and its outputs checked after it.
      @(negedge clk);
      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].rst, tbl[i].req, tbl[i].s0, tbl[i].i0, tbl[i].s1, tbl[i].i1,
               tbl[i].guest, tbl[i].v, tbl[i].pw, tbl[i].gw);
         @(negedge clk);
         check($sformatf("vec%0d", i), 32'(out_word()),
               32'({tbl[i].e_sreq, tbl[i].e_vo, tbl[i].e_pw, tbl[i].e_gw, tbl[i].e_busy,
                    tbl[i].e_score, tbl[i].e_id, tbl[i].e_guest, 1'b0}));
      end

      // Tie after reset: 0 then 1; a lone 0 then makes the next tie go 1 then 0.
      drive(1'b0, 2'b00, 7'd0, 3'd0, 7'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 2'b11, 7'd10, 3'd1, 7'd20, 3'd2, 2'b01, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 2'b00, 7'd0, 3'd0, 7'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
      serve(1'b0, 7'd10, 3'd1, 1'b1, 1'b1, 1'b0);
      serve(1'b1, 7'd20, 3'd2, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 2'b01, 7'd30, 3'd3, 7'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 2'b00, 7'd0, 3'd0, 7'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
      serve(1'b0, 7'd30, 3'd3, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 2'b11, 7'd40, 3'd4, 7'd50, 3'd6, 2'b10, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 2'b00, 7'd0, 3'd0, 7'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
      serve(1'b1, 7'd50, 3'd6, 1'b1, 1'b0, 1'b0);
      serve(1'b0, 7'd40, 3'd4, 1'b0, 1'b1, 1'b0);

      // Duplicate request while pending keeps the first capture, one response.
      drive(1'b1, 2'b10, 7'd0, 3'd0, 7'd9, 3'd4, 2'b10, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 2'b10, 7'd0, 3'd0, 7'd77, 3'd7, 2'b00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 2'b00, 7'd0, 3'd0, 7'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
      serve(1'b1, 7'd9, 3'd4, 1'b1, 1'b1, 1'b1);
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus_if.score_req === 1'b1 || bus_if.valid_out !== 2'b00) cnt++;
      end
      check("dup_no_second", cnt, 0);

`ifdef SCORE_ARB_TIMEOUT_EN
      // No tracker answer for four WAIT cycles abandons the transaction.
      drive(1'b1, 2'b01, 7'd55, 3'd6, 7'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 2'b00, 7'd0, 3'd0, 7'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
      cnt = 0;
      while (bus_if.score_req !== 1'b1 && cnt < 12) begin
         @(negedge clk);
         cnt++;
      end
      check("to_grant", 32'(cnt < 12), 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("to_quiet", {bus_if.timeout_out, bus_if.valid_out}, 3'b000);
      end
      @(negedge clk);
      check("to_pulse", {bus_if.timeout_out, bus_if.valid_out, bus_if.personalwin_out, bus_if.globalwin_out},
            {1'b1, 2'b01, 2'b00, 2'b00});
      @(negedge clk);
      check("to_after", {bus_if.busy, bus_if.timeout_out, bus_if.valid_out}, 4'b0000);
`endif

      // Randomized run against a transaction-level model.
      drive(1'b0, 2'b00, 7'd0, 3'd0, 7'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      mpend = 2'b00; mprev = 2'b00; mlast = 1'b1; awaiting = 1'b0;
      gcur = 1'b0; rpw = 1'b0; rgw = 1'b0; vo_due = -1; stall = 0; resp_delay = 0;
      for (int k = 0; k < 2; k++) begin
         mscore[k] = 7'd0; mid[k] = 3'd0; mguest[k] = 1'b0;
      end
      for (int cyc = 0; cyc < 2600; cyc++) begin
         @(negedge clk);
         // A response is due one edge after the edge that sampled valid_in.
         rel = 1'b0;
         if (vo_due > 0) vo_due--;
         if (vo_due == 0) begin
            exp_vo = onehot(gcur);
            rel    = 1'b1;
            vo_due = -1;
         end else begin
            exp_vo = 2'b00;
         end
         check("rand_resp", {bus_if.valid_out, bus_if.personalwin_out, bus_if.globalwin_out, bus_if.timeout_out},
               {exp_vo, exp_vo & {2{rpw}}, exp_vo & {2{rgw}}, 1'b0});
         // Pending set as seen by the grant two edges back, then this edge's update.
         pgrant = mprev;
         mprev  = mpend;
         if (rel) mpend[gcur] = 1'b0;
         if (bus_if.req_in[0] && !mpend[0]) begin
            mpend[0] = 1'b1; mscore[0] = bus_if.score0_in; mid[0] = bus_if.id0_in; mguest[0] = bus_if.guest_in[0];
         end
         if (bus_if.req_in[1] && !mpend[1]) begin
            mpend[1] = 1'b1; mscore[1] = bus_if.score1_in; mid[1] = bus_if.id1_in; mguest[1] = bus_if.guest_in[1];
         end
         if (bus_if.score_req === 1'b1) begin
            stall = 0;
            check("rand_sreq_legal", {awaiting, pgrant != 2'b00}, 2'b01);
            g = (pgrant == 2'b11) ? ~mlast : pgrant[1];
            check("rand_grant", {bus_if.score_out, bus_if.intPlayID_out, bus_if.isGuest_out},
                  {mscore[g], mid[g], mguest[g]});
            mlast      = g;
            gcur       = g;
            awaiting   = 1'b1;
            resp_delay = $urandom_range(0, 2);
         end else if (mpend != 2'b00) begin
            stall++;
         end else begin
            stall = 0;
         end
         check("rand_liveness", 32'(stall <= 16), 32'd1);
         if (stall > 16) stall = 0;
         // Tracker side: answer a waiting grant, otherwise send strays.
         if (awaiting && resp_delay == 0) begin
            rpw = 1'($urandom_range(0, 1));
            rgw = 1'($urandom_range(0, 1));
            bus_if.valid_in       = 1'b1;
            bus_if.personalwin_in = rpw;
            bus_if.globalwin_in   = rgw;
            vo_due   = 2;
            awaiting = 1'b0;
         end else begin
            if (awaiting) resp_delay--;
            bus_if.valid_in       = awaiting ? 1'b0 : ($urandom_range(0, 3) == 0);
            bus_if.personalwin_in = 1'($urandom_range(0, 1));
            bus_if.globalwin_in   = 1'($urandom_range(0, 1));
         end
         bus_if.req_in    = (cyc < 2500 && $urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         bus_if.score0_in = 7'($urandom_range(0, 127));
         bus_if.score1_in = 7'($urandom_range(0, 127));
         bus_if.id0_in    = 3'($urandom_range(0, 7));
         bus_if.id1_in    = 3'($urandom_range(0, 7));
         bus_if.guest_in  = 2'($urandom_range(0, 3));
      end
      check("rand_drained", {mpend, awaiting, 1'(vo_due < 0)}, 4'b0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
